conv_addr_stream_gen: RTL
=========================

# conv_addr_stream_gen

Parametrised address streamer for the fused-block convolution datapath: generates one IFM read address and one filter read address per beat for a KxK convolution with configurable stride, channel counts and PE-array width. It sits between the layer controller, which issues `start` plus the layer configuration, and the IFM/weight buffers feeding the PE array. It succeeds the fixed-size generator with:

- stride support
- arbitrary channel multiples
- ready/valid backpressure
- per-window last flags
- configuration checking

## Interface

Parameters:

- `ADDR_W`, 32, width of address ports and internal address arithmetic (wraps modulo 2^ADDR_W)
- `DIM_W`, 8, width of all dimension config inputs and loop counters
- `MUL_PER_PE`, 4, channels packed per fetched word (bytes per word; 1 byte per channel)
- `TOTAL_PE`, 16, output channels computed in parallel per OFM channel tile

Ports:

- `clk`  in  1  single clock
- `rst_n`  in  1  synchronous active-low reset, sampled on rising `clk`
- `start`  in  1  begin layer; sampled only in IDLE
- `cfg_kernel_w`  in  4  K (kernel width = height)
- `cfg_stride`  in  2  stride S (1..3)
- `cfg_ifm_w`  in  DIM_W  IFM width = height
- `cfg_ifm_c`  in  DIM_W  IFM channels
- `cfg_ofm_w`  in  DIM_W  OFM width = height
- `cfg_ofm_c`  in  DIM_W  OFM channels
- `ifm_base`  in  ADDR_W  IFM byte base address
- `filt_base`  in  ADDR_W  filter byte base address
- `addr_ready`  in  1  consumer accepts current beat
- `addr_valid`  out  1  beat present
- `ifm_addr`  out  ADDR_W  IFM word byte address
- `filt_addr`  out  ADDR_W  filter word byte address
- `win_last`  out  1  last beat of current (output pixel, OFM tile) window
- `busy`  out  1  high in CHECK/RUN/DONE
- `done`  out  1  one-cycle completion pulse
- `cfg_err`  out  1  one-cycle pulse coincident with `done` when config rejected

## Operation

- **States:** IDLE, CHECK, RUN, DONE.
- **IDLE → CHECK:** on `start`. All `cfg_*` and bases are latched on that edge; later `cfg_*` changes are ignored until the next start.
- **CHECK (1 cycle):** the config is rejected if any of the following holds; otherwise the next state is RUN.
  - K, S, `cfg_ofm_w`, `cfg_ifm_c` or `cfg_ofm_c` is 0
  - `cfg_ifm_c` is not a multiple of MUL_PER_PE
  - `cfg_ofm_c` is not a multiple of TOTAL_PE
  - (OFM_W−1)·S+K > IFM_W
- **Rejected config:** go to DONE with `cfg_err` set. No beat is issued.
- **Loop order, outermost first:** oy, ox, tile (OFM_C/TOTAL_PE), ky, kx, icw (IFM_C/MUL_PER_PE).
- **ifm_addr** = ifm_base + ((oy·S+ky)·IFM_W + ox·S+kx)·IFM_C + icw·MUL_PER_PE.
- **filt_addr** = filt_base + (((tile·K+ky)·K+kx)·NICW + icw)·MUL_PER_PE, where NICW = IFM_C/MUL_PER_PE. The filter stream restarts at filt_base for every output pixel.
- **Incremental arithmetic:** addresses are produced only with adders/comparators, no multipliers. Step values are precomputed in CHECK:
  - icw step: +MUL_PER_PE
  - kx step: +IFM_C
  - row step: IFM_W·IFM_C
  - ox step: S·IFM_C
  - oy step: S·IFM_W·IFM_C
- **Tile change:** on a tile change the IFM address rewinds to the window origin.
- **win_last:** high when ky=K−1, kx=K−1 and icw=NICW−1.
- **RUN → DONE:** when the final beat (all counters at max) is accepted.
- **DONE (1 cycle):** `done`=1, then IDLE.
- **Busy/reset:** `start` in a non-IDLE state is ignored. `rst_n`=0 in any state forces IDLE next edge; the in-flight layer is abandoned.

## Timing

- **Reset values:** `addr_valid`, `ifm_addr`, `filt_addr`, `win_last`, `busy`, `done`, `cfg_err` all 0; all counters 0.
- **Latency:** `start` at edge t → CHECK in cycle t+1 → first `addr_valid` in cycle t+2.
- **Handshake:** a beat transfers on an edge with `addr_valid`&`addr_ready`. While `addr_valid`&!`addr_ready`, all outputs are held stable. `addr_valid` never drops before transfer.
- **Throughput:** 1 beat/cycle with `addr_ready` held high. There are no bubbles at pixel, tile or row boundaries.
- **Completion:** `done` is asserted the cycle after the last transfer. `addr_valid` is 0 in DONE.
- **Beat count:** total beats = OFM_W²·(OFM_C/TOTAL_PE)·K²·NICW.
- **Outputs outside RUN:** `ifm_addr`/`filt_addr` hold their last value outside RUN and are don't-care while `addr_valid`=0.

## Test plan

- **Basic 3x3:** K=3, S=1, IFM 5x5x4, OFM 3x3x16, ifm_base=0x1000, filt_base=0x2000, ready=1 → 81 beats.
  - Beats 0–8 ifm: 0x1000, 0x1004, 0x1008, 0x1014, 0x1018, 0x101C, 0x1028, 0x102C, 0x1030.
  - Beats 0–8 filt: 0x2000..0x2020 step 4; `win_last` on beat 8.
  - Beat 9: ifm=0x1004, filt=0x2000.
  - `done` one cycle after beat 80.
- **Stride 2:** K=3, S=2, IFM 7x7x8, OFM 3x3x16 → 162 beats.
  - Beat 0 ifm=base, beat 1 = base+4.
  - Pixel (0,1) starts at base+0x10.
  - Pixel (1,0) starts at base+0x70.
- **Two OFM tiles:** IFM 5x5x4, OFM 3x3x32 → beat 9 filt=filt_base+0x24, ifm rewinds to 0x1000; 162 beats total.
- **Backpressure:** drive `addr_ready` with a pseudo-random 50% pattern on the basic case → the accepted address sequence is identical to the ready=1 run, with outputs held stable while stalled.
- **Config error:** `cfg_ifm_c`=6, or IFM_W=4 with OFM_W=3/K=3 → `done`=`cfg_err`=1 in cycle t+2, `addr_valid` never asserted, back to IDLE.
- **Reset mid-run:** `rst_n`=0 for one cycle at beat 20 → all outputs 0 next cycle. A new `start` then reproduces the full basic sequence from beat 0.

Source files
------------

// File: rtl/conv_addr_stream_gen.sv
// KxK convolution address streamer: one IFM and one filter word address per beat,
// with stride, channel tiling, ready/valid backpressure and configuration checking.
module conv_addr_stream_gen #(
  parameter int ADDR_W     = 32,
  parameter int DIM_W      = 8,
  parameter int MUL_PER_PE = 4,
  parameter int TOTAL_PE   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        cfg_kernel_w,
  input  logic [1:0]        cfg_stride,
  input  logic [DIM_W-1:0]  cfg_ifm_w,
  input  logic [DIM_W-1:0]  cfg_ifm_c,
  input  logic [DIM_W-1:0]  cfg_ofm_w,
  input  logic [DIM_W-1:0]  cfg_ofm_c,
  input  logic [ADDR_W-1:0] ifm_base,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] ifm_addr,
  output logic [ADDR_W-1:0] filt_addr,
  output logic              win_last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int SW = 2 * DIM_W;
  localparam logic [DIM_W-1:0]  ONE = DIM_W'(1);
  localparam logic [ADDR_W-1:0] MPP = ADDR_W'(MUL_PER_PE);

  logic [1:0]        state;
  logic [3:0]        k_q;
  logic [1:0]        s_q;
  logic [DIM_W-1:0]  iw_q, ic_q, ow_q, oc_q;
  logic [ADDR_W-1:0] ib_q, fb_q;
  logic [DIM_W-1:0]  k_m1, nicw_m1, tile_m1, ow_m1;
  logic [ADDR_W-1:0] c_step, row_step, ox_step, oy_step;
  logic [DIM_W-1:0]  oy, ox, tile, ky, kx, icw;
  // Nested origins: output row, window, kernel row, kernel pixel
  logic [ADDR_W-1:0] oy_base, win_base, row_base, pix_base;
  logic [ADDR_W-1:0] ifm_q, filt_q;
  logic              err_q;

  logic [ADDR_W-1:0] c_ext, row_mul;
  logic [SW-1:0]     span;
  logic              cfg_bad;

  always_comb begin
    c_ext   = ADDR_W'(ic_q);
    row_mul = ADDR_W'(iw_q) * c_ext;
    span    = (SW'(ow_q) - SW'(1)) * SW'(s_q) + SW'(k_q);
    cfg_bad = (k_q == '0) || (s_q == '0) || (ow_q == '0) || (ic_q == '0) || (oc_q == '0)
           || ((ic_q % DIM_W'(MUL_PER_PE)) != '0)
           || ((oc_q % DIM_W'(TOTAL_PE)) != '0)
           || (span > SW'(iw_q));
  end

  assign addr_valid = (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cfg_err    = (state == S_DONE) && err_q;
  assign ifm_addr   = ifm_q;
  assign filt_addr  = filt_q;
  assign win_last   = addr_valid && (ky == k_m1) && (kx == k_m1) && (icw == nicw_m1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      k_q <= '0; s_q <= '0; iw_q <= '0; ic_q <= '0; ow_q <= '0; oc_q <= '0;
      ib_q <= '0; fb_q <= '0;
      k_m1 <= '0; nicw_m1 <= '0; tile_m1 <= '0; ow_m1 <= '0;
      c_step <= '0; row_step <= '0; ox_step <= '0; oy_step <= '0;
      oy <= '0; ox <= '0; tile <= '0; ky <= '0; kx <= '0; icw <= '0;
      oy_base <= '0; win_base <= '0; row_base <= '0; pix_base <= '0;
      ifm_q <= '0; filt_q <= '0; err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k_q <= cfg_kernel_w; s_q <= cfg_stride;
          iw_q <= cfg_ifm_w; ic_q <= cfg_ifm_c; ow_q <= cfg_ofm_w; oc_q <= cfg_ofm_c;
          ib_q <= ifm_base; fb_q <= filt_base;
          state <= S_CHECK;
        end
        S_CHECK: begin
          err_q <= cfg_bad;
          oy <= '0; ox <= '0; tile <= '0; ky <= '0; kx <= '0; icw <= '0;
          if (cfg_bad) begin
            state <= S_DONE;
          end else begin
            k_m1     <= DIM_W'(k_q) - ONE;
            nicw_m1  <= ic_q / DIM_W'(MUL_PER_PE) - ONE;
            tile_m1  <= oc_q / DIM_W'(TOTAL_PE) - ONE;
            ow_m1    <= ow_q - ONE;
            c_step   <= c_ext;
            row_step <= row_mul;
            ox_step  <= ADDR_W'(s_q) * c_ext;
            oy_step  <= ADDR_W'(s_q) * row_mul;
            oy_base  <= ib_q; win_base <= ib_q; row_base <= ib_q; pix_base <= ib_q;
            ifm_q    <= ib_q;
            filt_q   <= fb_q;
            state    <= S_RUN;
          end
        end
        S_RUN: if (addr_ready) begin
          // Filter words are contiguous across tiles; rewind only at the end of a pixel
          filt_q <= (win_last && tile == tile_m1) ? fb_q : filt_q + MPP;
          if (icw != nicw_m1) begin
            icw <= icw + ONE; ifm_q <= ifm_q + MPP;
          end else begin
            icw <= '0;
            if (kx != k_m1) begin
              kx <= kx + ONE;
              pix_base <= pix_base + c_step; ifm_q <= pix_base + c_step;
            end else begin
              kx <= '0;
              if (ky != k_m1) begin
                ky <= ky + ONE;
                row_base <= row_base + row_step;
                pix_base <= row_base + row_step; ifm_q <= row_base + row_step;
              end else begin
                ky <= '0;
                if (tile != tile_m1) begin
                  tile <= tile + ONE;
                  row_base <= win_base; pix_base <= win_base; ifm_q <= win_base;
                end else begin
                  tile <= '0;
                  if (ox != ow_m1) begin
                    ox <= ox + ONE;
                    win_base <= win_base + ox_step; row_base <= win_base + ox_step;
                    pix_base <= win_base + ox_step; ifm_q <= win_base + ox_step;
                  end else begin
                    ox <= '0;
                    if (oy != ow_m1) begin
                      oy <= oy + ONE;
                      oy_base <= oy_base + oy_step; win_base <= oy_base + oy_step;
                      row_base <= oy_base + oy_step; pix_base <= oy_base + oy_step;
                      ifm_q <= oy_base + oy_step;
                    end else begin
                      oy <= '0;
                      state <= S_DONE;
                    end
                  end
                end
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
